// File: rtl/du_program_rx.sv
// Debug-unit program loader: pops a little-endian word count and that many
// little-endian instruction words from the UART Rx FIFO and writes them to IMEM.
module du_program_rx #(
  parameter int NB_INSTR     = 32,
  parameter int NB_UART_DATA = 8,
  parameter int NB_ADDR      = 10,
  parameter int IMEM_DEPTH   = 256
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_rx_empty,
  input  logic [NB_UART_DATA-1:0] i_rx_data,
  output logic                    o_rd,
  output logic                    o_imem_we,
  output logic [NB_ADDR-1:0]      o_imem_waddr,
  output logic [NB_INSTR-1:0]     o_imem_wdata,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_LEN,
    ST_CHECK,
    ST_RX_WORD,
    ST_WRITE,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           word_cnt_q, word_cnt_d;
  logic [31:0]           count_q, count_d;
  logic [NB_INSTR-1:0]   shift_q, shift_d;
  logic [NB_ADDR-1:0]    waddr_q, waddr_d;
  logic [NB_INSTR-1:0]   wdata_q, wdata_d;
  logic                  error_q, error_d;

  logic                  pop;
  logic                  last_byte;
  logic [NB_INSTR-1:0]   assembled;
  logic [31:0]           word_cnt_inc;

  // Bytes enter at the top and shift down, so byte k lands in bits [8k+7:8k].
  assign assembled    = {i_rx_data, shift_q[NB_INSTR-1:NB_UART_DATA]};
  assign last_byte    = (byte_cnt_q == 2'd3);
  assign pop          = o_rd;
  assign word_cnt_inc = word_cnt_q + 32'd1;

  // NOTE: every flop is updated with non-blocking assignments so all registers
  // see the pre-edge values of each other; reset clears each register explicitly.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      error_q    <= error_d;
    end
  end

  // NOTE: each always_comb assigns a default to every output first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (i_start) state_d = ST_RX_LEN;
      ST_RX_LEN:  if (pop && last_byte) state_d = ST_CHECK;
      ST_CHECK: begin
        if (count_q == 32'd0)                   state_d = ST_DONE;
        else if (count_q > 32'(IMEM_DEPTH))     state_d = ST_IDLE;
        else                                    state_d = ST_RX_WORD;
      end
      ST_RX_WORD: if (pop && last_byte) state_d = ST_WRITE;
      ST_WRITE:   state_d = (word_cnt_inc == count_q) ? ST_DONE : ST_RX_WORD;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    count_d    = count_q;
    shift_d    = shift_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    error_d    = error_q;

    if (state_q == ST_IDLE && i_start) begin
      error_d    = 1'b0;
      byte_cnt_d = '0;
      word_cnt_d = '0;
      waddr_d    = '0;
    end

    if (pop) begin
      shift_d    = assembled;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    if (state_q == ST_RX_LEN && pop && last_byte) begin
      count_d = assembled;
    end

    // Address and data are captured with the last byte so they are stable
    // throughout WRITE and hold afterwards.
    if (state_q == ST_RX_WORD && pop && last_byte) begin
      wdata_d = assembled;
      waddr_d = {word_cnt_q[NB_ADDR-3:0], 2'b00};
    end

    if (state_q == ST_CHECK && count_q > 32'(IMEM_DEPTH)) begin
      error_d = 1'b1;
    end

    if (state_q == ST_WRITE) begin
      word_cnt_d = word_cnt_inc;
    end
  end

  always_comb begin
    o_rd      = 1'b0;
    o_imem_we = 1'b0;
    o_done    = 1'b0;
    o_busy    = (state_q != ST_IDLE);
    unique case (state_q)
      ST_RX_LEN, ST_RX_WORD: o_rd      = !i_rx_empty;
      ST_WRITE:              o_imem_we = 1'b1;
      ST_DONE:               o_done    = 1'b1;
      default: ;
    endcase
  end

  assign o_imem_waddr = waddr_q;
  assign o_imem_wdata = wdata_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_du_program_rx.sv
// Self-checking bench for du_program_rx: a byte FIFO model feeds the loader and
// a monitor records pops, writes and done pulses by falling-edge index.
module tb_du_program_rx;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_rx_empty;
  logic [7:0]  i_rx_data;
  logic        o_rd;
  logic        o_imem_we;
  logic [9:0]  o_imem_waddr;
  logic [31:0] o_imem_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  always #5 clk = ~clk;

  du_program_rx #(
    .NB_INSTR(32), .NB_UART_DATA(8), .NB_ADDR(10), .IMEM_DEPTH(256)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_rx_empty(i_rx_empty), .i_rx_data(i_rx_data),
    .o_rd(o_rd), .o_imem_we(o_imem_we), .o_imem_waddr(o_imem_waddr),
    .o_imem_wdata(o_imem_wdata), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error)
  );

  typedef struct {
    string       name;
    logic [7:0]  bytes [16];
    int          nbytes;
    int          stall;
    int          exp_writes;
    logic [31:0] exp_word [3];
    bit          exp_err;
    int          exp_done;
  } vec_t;

  logic [7:0]  fifo_q [$];
  int          stall_len = 0;
  int          stall_cnt = 0;
  int          neg_n = 0;
  int          pop_ns [$];
  int          wr_ns [$];
  logic [9:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int          done_cnt = 0;
  int          done_n = 0;
  int          rd_viol = 0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model and monitor: observe at the falling edge, update after the rising edge.
  initial begin
    logic pop_pend;
    i_rx_empty = 1'b1;
    i_rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      neg_n++;
      pop_pend = o_rd;
      if (o_rd) begin
        pop_ns.push_back(neg_n);
        if (i_rx_empty) rd_viol++;
      end
      if (o_imem_we) begin
        wr_ns.push_back(neg_n);
        wr_addr.push_back(o_imem_waddr);
        wr_data.push_back(o_imem_wdata);
      end
      if (o_done) begin
        done_cnt++;
        done_n = neg_n;
      end
      @(posedge clk);
      #1;
      if (pop_pend && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        stall_cnt = stall_len;
      end else if (stall_cnt > 0) begin
        stall_cnt--;
      end
      i_rx_empty = (fifo_q.size() == 0) || (stall_cnt > 0);
      i_rx_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  task automatic clear_records();
    pop_ns.delete();
    wr_ns.delete();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    rd_viol  = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int exit_n);
    bit fell = 1'b0;
    exit_n = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); #1;
      if (!o_busy) begin
        fell   = 1'b1;
        exit_n = neg_n;
        break;
      end
    end
    check({name, "_busy_falls"}, 64'(fell), 64'd1);
  endtask

  task automatic run_case(input vec_t v);
    int exit_n;
    clear_records();
    stall_len = v.stall;
    for (int b = 0; b < v.nbytes; b++) fifo_q.push_back(v.bytes[b]);
    pulse_start();
    wait_idle(v.name, exit_n);
    check({v.name, "_writes"}, 64'(wr_ns.size()), 64'(v.exp_writes));
    for (int w = 0; w < v.exp_writes && w < wr_ns.size(); w++) begin
      check($sformatf("%s_addr%0d", v.name, w), 64'(wr_addr[w]), 64'(w * 4));
      check($sformatf("%s_data%0d", v.name, w), 64'(wr_data[w]), 64'(v.exp_word[w]));
      if (4 * w + 7 < pop_ns.size())
        check($sformatf("%s_wr_lat%0d", v.name, w), 64'(wr_ns[w] - pop_ns[4 * w + 7]), 64'd1);
    end
    check({v.name, "_pops"}, 64'(pop_ns.size()), 64'(v.nbytes));
    check({v.name, "_done_cnt"}, 64'(done_cnt), 64'(v.exp_done));
    check({v.name, "_error"}, 64'(o_error), 64'(v.exp_err));
    check({v.name, "_rd_when_empty"}, 64'(rd_viol), 64'd0);
    check({v.name, "_fifo_left"}, 64'(fifo_q.size()), 64'd0);
    if (pop_ns.size() > 0) begin
      if (v.exp_done > 0) begin
        if (v.exp_writes > 0 && wr_ns.size() > 0)
          check({v.name, "_done_after_wr"}, 64'(done_n - wr_ns[wr_ns.size() - 1]), 64'd1);
        else if (v.exp_writes == 0)
          check({v.name, "_done_after_pop"}, 64'(done_n - pop_ns[pop_ns.size() - 1]), 64'd2);
        check({v.name, "_busy_with_done"}, 64'(exit_n - done_n), 64'd1);
      end else begin
        check({v.name, "_idle_after_check"}, 64'(exit_n - pop_ns[pop_ns.size() - 1]), 64'd2);
      end
    end
    stall_len = 0;
  endtask

  vec_t vecs [4];
  vec_t fresh;

  initial begin
    int exit_n;
    bit  seen;

    vecs[0].name = "load3";
    vecs[0].bytes = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                      8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    vecs[0].nbytes = 16; vecs[0].stall = 0; vecs[0].exp_writes = 3;
    vecs[0].exp_word = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
    vecs[0].exp_err = 1'b0; vecs[0].exp_done = 1;

    vecs[1].name = "zero";
    vecs[1].bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].nbytes = 4; vecs[1].stall = 0; vecs[1].exp_writes = 0;
    vecs[1].exp_word = '{32'h0, 32'h0, 32'h0};
    vecs[1].exp_err = 1'b0; vecs[1].exp_done = 1;

    vecs[2].name = "oversize";
    vecs[2].bytes = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].nbytes = 4; vecs[2].stall = 0; vecs[2].exp_writes = 0;
    vecs[2].exp_word = '{32'h0, 32'h0, 32'h0};
    vecs[2].exp_err = 1'b1; vecs[2].exp_done = 0;

    vecs[3].name = "stall";
    vecs[3].bytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].nbytes = 8; vecs[3].stall = 5; vecs[3].exp_writes = 1;
    vecs[3].exp_word = '{32'hDEAD_BEEF, 32'h0, 32'h0};
    vecs[3].exp_err = 1'b0; vecs[3].exp_done = 1;

    fresh = vecs[3];
    fresh.name  = "fresh";
    fresh.bytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fresh.stall = 0;
    fresh.exp_word = '{32'h1234_5678, 32'h0, 32'h0};

    i_rst   = 1'b0;
    i_start = 1'b0;
    #1;
    check("reset_outputs",
          64'({o_rd, o_imem_we, o_busy, o_done, o_error, o_imem_waddr, o_imem_wdata}), 64'd0);
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b1;
    @(negedge clk); #1;
    check("idle_after_reset", 64'(o_busy), 64'd0);

    for (int i = 0; i < 4; i++) run_case(vecs[i]);

    // Error stays set while idle and is cleared by the next accepted start.
    run_case(vecs[2]);
    repeat (3) @(negedge clk);
    #1 check("error_sticky", 64'(o_error), 64'd1);
    clear_records();
    for (int b = 0; b < 4; b++) fifo_q.push_back(8'h00);
    pulse_start();
    @(negedge clk); #1;
    check("error_cleared_by_start", 64'(o_error), 64'd0);
    wait_idle("error_clear_load", exit_n);
    check("error_clear_done_cnt", 64'(done_cnt), 64'd1);

    // Asynchronous reset after two bytes of the first instruction word.
    clear_records();
    for (int b = 0; b < 6; b++) fifo_q.push_back(vecs[3].bytes[b]);
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (pop_ns.size() >= 6) begin seen = 1'b1; break; end
    end
    check("midword_pops_seen", 64'(seen), 64'd1);
    @(posedge clk); #2 i_rst = 1'b0;
    #1;
    check("midword_reset_outputs",
          64'({o_rd, o_imem_we, o_busy, o_done, o_error, o_imem_waddr, o_imem_wdata}), 64'd0);
    repeat (2) @(negedge clk);
    #1 check("midword_no_write", 64'(wr_ns.size()), 64'd0);
    @(posedge clk); #1 i_rst = 1'b1;
    @(negedge clk); #1;
    check("midword_idle", 64'(o_busy), 64'd0);
    run_case(fresh);

    // Start pulses while receiving and writing words must be ignored.
    clear_records();
    begin
      logic [7:0] seq [12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                               8'h55, 8'h66, 8'h77, 8'h88};
      for (int b = 0; b < 12; b++) fifo_q.push_back(seq[b]);
    end
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk); #1;
      if (wr_ns.size() >= 2) begin i_start = 1'b0; seen = 1'b1; break; end
      else if (pop_ns.size() >= 5) i_start = 1'b1;
    end
    i_start = 1'b0;
    check("ign_second_write_seen", 64'(seen), 64'd1);
    wait_idle("ign", exit_n);
    repeat (4) @(negedge clk);
    #1 check("ign_stays_idle", 64'(o_busy), 64'd0);
    check("ign_writes", 64'(wr_ns.size()), 64'd2);
    if (wr_ns.size() == 2) begin
      check("ign_addr0", 64'(wr_addr[0]), 64'd0);
      check("ign_data0", 64'(wr_data[0]), 64'h4433_2211);
      check("ign_addr1", 64'(wr_addr[1]), 64'd4);
      check("ign_data1", 64'(wr_data[1]), 64'h8877_6655);
    end
    check("ign_done_cnt", 64'(done_cnt), 64'd1);
    check("ign_pops", 64'(pop_ns.size()), 64'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
